// File: rtl/rover_sensor_pkg.sv
// Shared definitions for the rover ultrasonic ranging path: FSM states and
// 50 MHz timing defaults derived from the clock rate and sound-speed constant.
package rover_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } ranger_state_t;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned CYCLES_PER_CM = 2900;
  localparam int          CNT_W         = 24;

  localparam int unsigned DEF_TRIG_CYCLES    = CLK_HZ / 100_000;
  localparam int unsigned DEF_ECHO_TIMEOUT   = CLK_HZ / 40;
  localparam int unsigned DEF_MEAS_PERIOD    = (CLK_HZ / 100) * 6;
  localparam int unsigned DEF_THRESH_CYCLES  = 20 * CYCLES_PER_CM;
  localparam int unsigned DEF_RELEASE_CYCLES = 25 * CYCLES_PER_CM;
  localparam int unsigned DEF_FILTER_COUNT   = 3;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous echo pin, with a rising-edge
// detect built from the synchronized level and its previous sample.
module echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic echo,
  output logic echo_s,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign echo_s = sync2;
  assign rise   = sync2 & ~prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing and near/far
// hysteresis. Define DETECT_FILTER_EN to require FILTER_COUNT agreeing readings.
module ultrasonic_ranger
  import rover_sensor_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned ECHO_TIMEOUT   = DEF_ECHO_TIMEOUT,
  parameter int unsigned MEAS_PERIOD    = DEF_MEAS_PERIOD,
  parameter int unsigned THRESH_CYCLES  = DEF_THRESH_CYCLES,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int unsigned FILTER_COUNT   = DEF_FILTER_COUNT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        echo,
  output logic        trig,
  output logic        object_detected,
  output logic [23:0] echo_cycles,
  output logic        meas_valid,
  output logic        timeout
);

  if (!(THRESH_CYCLES < RELEASE_CYCLES && RELEASE_CYCLES <= ECHO_TIMEOUT &&
        MEAS_PERIOD > TRIG_CYCLES + 2 * ECHO_TIMEOUT + 4 &&
        FILTER_COUNT >= 1 && FILTER_COUNT <= 255 && TRIG_CYCLES >= 1)) begin : g_bad_params
    $error("ultrasonic_ranger: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(MEAS_PERIOD - 1);
  localparam logic [CNT_W-1:0] THRESH_VAL   = CNT_W'(THRESH_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_VAL  = CNT_W'(RELEASE_CYCLES);

  logic echo_s;
  logic rise;

  echo_sync u_echo_sync (
    .clock  (clock),
    .reset  (reset),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (rise)
  );

  ranger_state_t    state;
  ranger_state_t    state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_next;
  logic             finish;
  logic             finish_tmo;
  logic [CNT_W-1:0] finish_result;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      period_cnt <= '0;
      trig       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      period_cnt <= period_next;
      trig       <= (state_next == TRIG);
    end
  end

  // cnt is shared: trigger length in TRIG, wait time in WAIT_RISE, width in MEASURE
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    period_next   = period_cnt + CNT_W'(1);
    finish        = 1'b0;
    finish_tmo    = 1'b0;
    finish_result = cnt;
    case (state)
      IDLE: begin
        state_next  = TRIG;
        cnt_next    = '0;
        period_next = '0;
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = CNT_W'(1);
        end else if (cnt == TIMEOUT_LAST) begin
          state_next    = HOLDOFF;
          finish        = 1'b1;
          finish_tmo    = 1'b1;
          finish_result = TIMEOUT_VAL;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_next = HOLDOFF;
          finish     = 1'b1;
        end else if (cnt == TIMEOUT_VAL) begin
          state_next    = HOLDOFF;
          finish        = 1'b1;
          finish_tmo    = 1'b1;
          finish_result = TIMEOUT_VAL;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (period_cnt == PERIOD_LAST) begin
          state_next  = TRIG;
          cnt_next    = '0;
          period_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic near;
  logic far;
  assign near = (finish_result < THRESH_VAL);
  assign far  = finish_tmo || (finish_result >= RELEASE_VAL);

`ifdef DETECT_FILTER_EN
  localparam logic [7:0] FILTER_LAST = 8'(FILTER_COUNT - 1);
  localparam logic [7:0] FILTER_VAL  = 8'(FILTER_COUNT);
  logic [7:0] near_run;
  logic [7:0] far_run;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      meas_valid      <= 1'b0;
      echo_cycles     <= '0;
      timeout         <= 1'b0;
      object_detected <= 1'b0;
`ifdef DETECT_FILTER_EN
      near_run        <= '0;
      far_run         <= '0;
`endif
    end else begin
      meas_valid <= finish;
      if (finish) begin
        echo_cycles <= finish_result;
        timeout     <= finish_tmo;
`ifdef DETECT_FILTER_EN
        // run counters saturate at FILTER_COUNT; a band reading breaks both runs
        if (near) begin
          far_run <= '0;
          if (near_run < FILTER_VAL) near_run <= near_run + 8'd1;
          if (near_run >= FILTER_LAST) object_detected <= 1'b1;
        end else if (far) begin
          near_run <= '0;
          if (far_run < FILTER_VAL) far_run <= far_run + 8'd1;
          if (far_run >= FILTER_LAST) object_detected <= 1'b0;
        end else begin
          near_run <= '0;
          far_run  <= '0;
        end
`else
        if (near) object_detected <= 1'b1;
        else if (far) object_detected <= 1'b0;
`endif
      end
    end
  end

endmodule
